flash_ctrl: RTL and testbench
=============================

Name: flash_ctrl

Overview:
- Read-only controller between the CPU-side bus and the off-chip x16 parallel NOR flash.
- Accepts a word read request with a byte address.
- Performs two timed halfword reads on the flash pins and assembles a 32-bit little-endian word.
- Returns the word with a one-cycle ready pulse.
- Sits directly downstream of the flash bus-side logic; drives the board flash pins.

Parameters:
- READ_WAIT_CYCLES, 4, cycles flash_oe_n is held low per halfword before data is sampled; legal range 1..15.
- FLASH_ADDR_W, 23, width of Flash_addr_t and flash_a (byte address, 8 MB space).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- bus_addr  in  FLASH_ADDR_W  byte address of the requested word; bits [1:0] ignored.
- read_op  in  1  level request; sampled only in IDLE.
- bus_data_read  out  32  assembled word, held until the next completed read.
- bus_ready  out  1  one-cycle pulse; bus_data_read valid in the same cycle.
- flash_a  out  FLASH_ADDR_W  flash byte address; bit 0 is always 0 (x16 mode).
- flash_d  inout  16  flash data bus; always high-Z from this block.
- flash_ce_n  out  1  chip enable, active low.
- flash_oe_n  out  1  output enable, active low.
- flash_we_n  out  1  write enable; constant 1.
- flash_rp_n  out  1  flash reset; constant 1.
- flash_byte_n  out  1  constant 1 (x16 mode).
- flash_vpen  out  1  constant 0 (write-protected).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, wait counter=0.
  - bus_data_read=32'h0, bus_ready=0, flash_a=0.
  - flash_ce_n=1, flash_oe_n=1.
  - Constant pins hold their values at all times.
- Reset mid-transaction aborts immediately: the next edge gives reset values, the partial halfword is discarded, and no bus_ready pulse is issued.
- States: IDLE, READ_LO, READ_HI, DONE.
- IDLE:
  - ce_n=1, oe_n=1.
  - If read_op==1 at the edge: latch base={bus_addr[FLASH_ADDR_W-1:2],2'b00}, set flash_a=base, counter=0, go to READ_LO.
- READ_LO:
  - ce_n=0, oe_n=0, flash_a=base.
  - Counter increments each cycle.
  - At the edge where counter==READ_WAIT_CYCLES-1: capture lo=flash_d, set flash_a=base+2, counter=0, go to READ_HI.
- READ_HI:
  - Same timing as READ_LO.
  - At the final edge: capture hi=flash_d, load bus_data_read={hi,lo}, go to DONE.
- DONE:
  - bus_ready=1 for exactly this cycle; ce_n=1, oe_n=1.
  - Go to IDLE unconditionally.
- Latency: with the accepting edge as cycle 0, bus_ready is high in cycle 2*READ_WAIT_CYCLES+1. Default: cycle 9.
- read_op changes after acceptance are ignored; the transaction always completes.
- read_op held high continuously gives back-to-back reads with one IDLE cycle between them.
- Address wrap: base+2 never carries out of the word, since base[1:0]==0.
- bus_data_read is unchanged by aborted transactions and by IDLE cycles.
- Counter width is 4 bits; the counter never exceeds READ_WAIT_CYCLES-1.

Decomposition:
- Shared package (defines.svh):
  - Flash_addr_t, Halfword_t (16 bits); Word_t and Bit_t already exist.
  - Flash_state_t enum {IDLE, READ_LO, READ_HI, DONE}.
  - Constant FLASH_READ_WAIT_DEFAULT=4.
- RTL sub-module: none; counter and FSM stay in one module.
- Bench-side: companion behavioural model flash_model (x16 array, tri-state output gated by ce_n/oe_n, outputs X when the address changes within a phase).

Test Plan:
- Basic read: model halfword@0x000100=16'h5678, @0x000102=16'h1234; read_op pulse with bus_addr=0x000100 -> bus_ready in cycle 9, bus_data_read=32'h12345678, flash_a sequence 0x000100 then 0x000102.
- Unaligned address: bus_addr=0x000103 with the same contents -> identical access to 0x000100/0x000102, result 32'h12345678.
- Back-to-back: read_op held high over addrs 0x000000 (=32'hDEADBEEF) then 0x7FFFFC (=32'hCAFEF00D) -> two ready pulses 10 cycles apart, correct words, top address without wrap error.
- Reset mid-operation: rst=0 during READ_HI -> next edge ce_n=oe_n=1, bus_ready never pulses, bus_data_read=0; the next read after reset returns correct data.
- READ_WAIT_CYCLES=1: read of 0x000010 -> bus_ready in cycle 3, data correct; oe_n low exactly 2 cycles.
- Idle check: read_op=0 for 50 cycles after reset -> ce_n=oe_n=1, flash_d high-Z, bus_ready=0, we_n=1, vpen=0 throughout.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared types and constants for the x16 NOR flash read controller.
package flash_ctrl_pkg;

    localparam int FLASH_ADDR_W_DEFAULT    = 23;
    localparam int FLASH_READ_WAIT_DEFAULT = 4;

    typedef logic                            Bit_t;
    typedef logic [31:0]                     Word_t;
    typedef logic [15:0]                     Halfword_t;
    typedef logic [FLASH_ADDR_W_DEFAULT-1:0] Flash_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_LO,
        READ_HI,
        DONE
    } Flash_state_t;

endpackage

// File: rtl/flash_ctrl.sv
// Read-only bridge: one bus word read becomes two timed x16 halfword reads
// on the NOR flash pins, assembled little-endian into a 32-bit word.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int READ_WAIT_CYCLES = FLASH_READ_WAIT_DEFAULT,
    parameter int FLASH_ADDR_W     = FLASH_ADDR_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLASH_ADDR_W-1:0] bus_addr,
    input  logic                    read_op,
    output Word_t                   bus_data_read,
    output Bit_t                    bus_ready,
    output logic [FLASH_ADDR_W-1:0] flash_a,
    inout  wire  [15:0]             flash_d,
    output logic                    flash_ce_n,
    output logic                    flash_oe_n,
    output logic                    flash_we_n,
    output logic                    flash_rp_n,
    output logic                    flash_byte_n,
    output logic                    flash_vpen,
    output Flash_state_t            o_dbg_state
);

    localparam logic [3:0] CNT_LAST = 4'(READ_WAIT_CYCLES - 1);

    // Handshake: read_op is a level request seen only in IDLE; once taken the
    // read always completes and bus_ready pulses for one cycle with the data.
    Flash_state_t            r_state;
    Flash_state_t            w_next_state;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    w_phase_end;
    logic [FLASH_ADDR_W-1:0] r_base;
    logic [FLASH_ADDR_W-1:0] r_flash_a;
    Halfword_t               r_lo;
    Word_t                   r_data;
    logic                    w_reading;
    logic                    w_unused_addr_lsbs;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_phase_end  = (r_cnt == CNT_LAST);
        case (r_state)
            IDLE: begin
                if (read_op) begin
                    w_next_state = READ_LO;
                    w_cnt_next   = 4'd0;
                end
            end
            READ_LO: begin
                if (w_phase_end) begin
                    w_next_state = READ_HI;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            READ_HI: begin
                if (w_phase_end) begin
                    w_next_state = DONE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_base    <= '0;
            r_flash_a <= '0;
            r_lo      <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            case (r_state)
                IDLE: begin
                    if (read_op) begin
                        r_base    <= {bus_addr[FLASH_ADDR_W-1:2], 2'b00};
                        r_flash_a <= {bus_addr[FLASH_ADDR_W-1:2], 2'b00};
                    end
                end
                READ_LO: begin
                    // base is word aligned, so +2 stays inside the same word
                    if (w_phase_end) begin
                        r_lo      <= flash_d;
                        r_flash_a <= r_base + FLASH_ADDR_W'(2);
                    end
                end
                READ_HI: begin
                    if (w_phase_end) begin
                        r_data <= {flash_d, r_lo};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_reading          = (r_state == READ_LO) || (r_state == READ_HI);
    assign w_unused_addr_lsbs = ^bus_addr[1:0];

    assign bus_data_read = r_data;
    assign bus_ready     = (r_state == DONE);
    assign flash_a       = r_flash_a;
    assign flash_ce_n    = !w_reading;
    assign flash_oe_n    = !w_reading;
    assign flash_we_n    = 1'b1;
    assign flash_rp_n    = 1'b1;
    assign flash_byte_n  = 1'b1;
    assign flash_vpen    = 1'b0;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_flash_ctrl.sv
// Bench for flash_ctrl: two instances (default wait and wait=1), each with an
// x16 flash model, a scoreboard queue and a monitor checking every ready pulse.
module tb_flash_ctrl;
    import flash_ctrl_pkg::*;

    localparam int AW = 23;
    localparam int W0 = 4;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- unit 0 (READ_WAIT_CYCLES = 4) ----------------
    logic [AW-1:0] addr0 = '0;
    logic          rd0 = 1'b0;
    logic [31:0]   data0;
    logic          rdy0, ce0, oe0, we0, rp0, byte0, vpen0;
    logic [AW-1:0] fa0;
    wire  [15:0]   fd0;
    Flash_state_t  st0;

    // ---------------- unit 1 (READ_WAIT_CYCLES = 1) ----------------
    logic [AW-1:0] addr1 = '0;
    logic          rd1 = 1'b0;
    logic [31:0]   data1;
    logic          rdy1, ce1, oe1, we1, rp1, byte1, vpen1;
    logic [AW-1:0] fa1;
    wire  [15:0]   fd1;
    Flash_state_t  st1;

    flash_ctrl #(.READ_WAIT_CYCLES(W0), .FLASH_ADDR_W(AW)) u_dut0 (
        .clk(clk), .rst(rst), .bus_addr(addr0), .read_op(rd0),
        .bus_data_read(data0), .bus_ready(rdy0), .flash_a(fa0), .flash_d(fd0),
        .flash_ce_n(ce0), .flash_oe_n(oe0), .flash_we_n(we0), .flash_rp_n(rp0),
        .flash_byte_n(byte0), .flash_vpen(vpen0), .o_dbg_state(st0)
    );

    flash_ctrl #(.READ_WAIT_CYCLES(W1), .FLASH_ADDR_W(AW)) u_dut1 (
        .clk(clk), .rst(rst), .bus_addr(addr1), .read_op(rd1),
        .bus_data_read(data1), .bus_ready(rdy1), .flash_a(fa1), .flash_d(fd1),
        .flash_ce_n(ce1), .flash_oe_n(oe1), .flash_we_n(we1), .flash_rp_n(rp1),
        .flash_byte_n(byte1), .flash_vpen(vpen1), .o_dbg_state(st1)
    );

    // ---------------- flash model: sparse x16 array, hashed default contents ----------------
    logic [15:0] mem [int];

    function automatic logic [15:0] hw(input logic [AW-1:0] a);
        logic [31:0] t;
        if (mem.exists(int'(a))) return mem[int'(a)];
        t = {9'b0, a} * 32'h9E3779B1;
        return t[31:16];
    endfunction

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        return {hw(b + 23'd2), hw(b)};
    endfunction

    assign fd0 = (!ce0 && !oe0) ? hw(fa0) : 16'hzzzz;
    assign fd1 = (!ce1 && !oe1) ? hw(fa1) : 16'hzzzz;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] base;
        int            acc;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    int            oe_cnt[2];
    int            a_n[2];
    logic [AW-1:0] a_first[2];
    logic [AW-1:0] a_second[2];
    logic [AW-1:0] a_last[2];
    logic [31:0]   held[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int u, input logic rdy, input logic [31:0] d,
                       input logic oe, input logic [AW-1:0] fa, input int w);
        exp_t e;
        int   qs;
        if (!rst) begin
            oe_cnt[u] = 0;
            a_n[u]    = 0;
            held[u]   = 32'h0;
            return;
        end
        if (!oe) begin
            oe_cnt[u]++;
            if (a_n[u] == 0 || fa != a_last[u]) begin
                a_n[u]++;
                if (a_n[u] == 1) a_first[u] = fa;
                else if (a_n[u] == 2) a_second[u] = fa;
            end
            a_last[u] = fa;
        end
        if (!rdy) begin
            check($sformatf("u%0d_held_data", u), d, held[u]);
            return;
        end
        qs = (u == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL u%0d_unexpected_ready: got ready=1 expected no pulse (cycle %0d)", u, cyc);
        end else begin
            if (u == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("u%0d_data", u), d, e.data);
            check($sformatf("u%0d_latency", u), 32'(cyc - e.acc), 32'(2 * w + 1));
            check($sformatf("u%0d_oe_low_cycles", u), 32'(oe_cnt[u]), 32'(2 * w));
            check($sformatf("u%0d_addr_count", u), 32'(a_n[u]), 32'd2);
            check($sformatf("u%0d_addr_lo", u), 32'(a_first[u]), 32'(e.base));
            check($sformatf("u%0d_addr_hi", u), 32'(a_second[u]), 32'(e.base + 23'd2));
            held[u] = e.data;
        end
        oe_cnt[u] = 0;
        a_n[u]    = 0;
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, rdy0, data0, oe0, fa0, W0);
        mon(1, rdy1, data1, oe1, fa1, W1);
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int u, input logic r, input logic [AW-1:0] a);
        if (u == 0) begin rd0 = r; addr0 = a; end
        else        begin rd1 = r; addr1 = a; end
    endtask

    // Presents a request for one cycle of acceptance, then keeps driving
    // (ignored) noise until the controller is back in IDLE.
    task automatic issue(input int u, input logic [AW-1:0] a, input bit noisy);
        exp_t e;
        int   w;
        w = (u == 0) ? W0 : W1;
        @(negedge clk);
        set_in(u, 1'b1, a);
        e.data = word_at(a);
        e.base = {a[AW-1:2], 2'b00};
        e.acc  = cyc;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int i = 1; i <= 2 * w + 1; i++) begin
            @(negedge clk);
            set_in(u, noisy ? 1'($urandom_range(0, 1)) : 1'b1, 23'($urandom));
        end
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        @(negedge clk);
        set_in(u, 1'b0, 23'($urandom));
        while (((u == 0) ? q0.size() : q1.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_drain_in_time", u), 32'(n < 100), 32'd1);
    endtask

    task automatic check_idle_pins(input int u);
        if (u == 0) check("u0_idle_pins", {25'b0, ce0, oe0, rdy0, we0, rp0, byte0, vpen0}, 32'b1101110);
        else        check("u1_idle_pins", {25'b0, ce1, oe1, rdy1, we1, rp1, byte1, vpen1}, 32'b1101110);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h000100] = 16'h5678;
        mem[32'h000102] = 16'h1234;
        mem[32'h000000] = 16'hBEEF;
        mem[32'h000002] = 16'hDEAD;
        mem[32'h7FFFFC] = 16'hF00D;
        mem[32'h7FFFFE] = 16'hCAFE;
        mem[32'h000200] = 16'h3C3C;
        mem[32'h000202] = 16'h9A9A;
        mem[32'h000010] = 16'hA1B2;
        mem[32'h000012] = 16'hC3D4;

        // reset values
        repeat (3) @(negedge clk);
        check("u0_reset_data", data0, 32'h0);
        check("u0_reset_addr", 32'(fa0), 32'h0);
        check("u0_reset_state", 32'(st0), 32'(IDLE));
        check_idle_pins(0);
        check("u1_reset_data", data1, 32'h0);
        check_idle_pins(1);
        rst = 1'b1;

        // idle: nothing requested, pins stay parked
        repeat (50) begin
            @(negedge clk);
            check_idle_pins(0);
            check_idle_pins(1);
        end

        // basic, unaligned, back-to-back incl. top of address space
        issue(0, 23'h000100, 1'b0);
        drain(0);
        issue(0, 23'h000103, 1'b0);
        drain(0);
        issue(0, 23'h000000, 1'b0);
        issue(0, 23'h7FFFFC, 1'b0);
        drain(0);

        // reset during READ_HI discards the transaction
        @(negedge clk);
        set_in(0, 1'b1, 23'h000200);
        @(negedge clk);
        set_in(0, 1'b0, 23'h0);
        repeat (W0 + 1) @(negedge clk);
        check("u0_in_read_hi", 32'(st0), 32'(READ_HI));
        rst = 1'b0;
        @(negedge clk);
        check("u0_abort_ce_oe", {30'b0, ce0, oe0}, 32'h3);
        check("u0_abort_ready", {31'b0, rdy0}, 32'h0);
        check("u0_abort_data", data0, 32'h0);
        check("u0_abort_addr", 32'(fa0), 32'h0);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        issue(0, 23'h000200, 1'b0);
        drain(0);

        // randomized reads, noisy read_op while busy, some back-to-back
        for (int i = 0; i < 12; i++) begin
            issue(0, 23'($urandom), 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                drain(0);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        drain(0);

        // minimum wait setting
        issue(1, 23'h000010, 1'b0);
        drain(1);
        for (int i = 0; i < 8; i++) begin
            issue(1, 23'($urandom), 1'b1);
            if ($urandom_range(0, 1) != 0) drain(1);
        end
        drain(1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
